exec_ctrl: RTL

- Multi-cycle execute sequencer for the 8-bit datapath. It sits beside the 32×8 general-purpose register file and drives it in both directions.
- Upstream: it turns one accepted instruction into a register-file read cycle, an ALU evaluation and a register-file write-back cycle.
- Downstream: it consumes the register file's registered outA/outB and produces the write-back data and Z/C flags.

---
 rtl/exec_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exec_ctrl
// Description : Multi-cycle execute sequencer for the 8-bit datapath. Turns
//               one accepted instruction into a register-file read, an ALU
//               evaluation and a register-file write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module exec_ctrl #(
  parameter int IW = 20
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [4:0]    rf_ra,
  output logic [4:0]    rf_rb,
  output logic          rf_we,
  output logic [7:0]    rf_wd,
  input  logic [7:0]    rf_outA,
  input  logic [7:0]    rf_outB,
  output logic          done,
  output logic [7:0]    result_out,
  output logic          flag_z,
  output logic          flag_c
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  state_t      state;
  state_t      state_nxt;

  // Only instr[19:2] carries information; bits [1:0] are never decoded.
  logic [17:0] instr_q;
  logic [7:0]  res_q;
  logic [4:0]  ra_hold;
  logic [4:0]  rb_hold;
  logic [7:0]  wd_hold;
  logic        accept;

  logic [2:0]  in_op;
  logic [2:0]  op_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [7:0]  imm_q;

  logic [7:0]  alu_res;
  logic        alu_c;
  logic [8:0]  sum9;
  logic        unused_bits;

  assign unused_bits = ^instr[1:0];

  assign in_op  = instr[19:17];
  assign op_q   = instr_q[17:15];
  assign rd_q   = instr_q[14:10];
  assign rs1_q  = instr_q[9:5];
  assign rs2_q  = instr_q[4:0];
  assign imm_q  = instr_q[9:2];
  assign accept = instr_valid && (state == S_IDLE);
  assign sum9   = {1'b0, rf_outA} + {1'b0, rf_outB};

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and register-file/handshake decode from the registered state.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    done        = 1'b0;
    rf_we       = 1'b0;
    rf_ra       = ra_hold;
    rf_rb       = rb_hold;
    rf_wd       = wd_hold;
    case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_nxt = ((in_op == OP_LDI) || (in_op == OP_NOP)) ? S_WB : S_READ;
        end
      end
      S_READ: begin
        rf_ra     = rs1_q;
        rf_rb     = rs2_q;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_WB;
      end
      S_WB: begin
        rf_ra     = rd_q;
        rf_wd     = res_q;
        done      = 1'b1;
        rf_we     = (op_q != OP_NOP);
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // ALU on the register file's registered read data.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD: {alu_c, alu_res} = sum9;
      OP_SUB: begin
        alu_res = rf_outA - rf_outB;
        alu_c   = (rf_outA < rf_outB);
      end
      OP_AND: alu_res = rf_outA & rf_outB;
      OP_OR:  alu_res = rf_outA | rf_outB;
      OP_XOR: alu_res = rf_outA ^ rf_outB;
      OP_SHL: alu_res = rf_outA << rf_outB[2:0];
      default: begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Instruction latch, result/flag registers and address/data hold registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q    <= '0;
      res_q      <= 8'h00;
      result_out <= 8'h00;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      ra_hold    <= 5'd0;
      rb_hold    <= 5'd0;
      wd_hold    <= 8'h00;
    end else begin
      ra_hold <= rf_ra;
      rb_hold <= rf_rb;
      wd_hold <= rf_wd;
      if (accept) begin
        instr_q <= instr[19:2];
        // LDI skips EXEC, so its immediate becomes the result at accept.
        if (in_op == OP_LDI) res_q <= instr[11:4];
      end
      // Only ALU-class opcodes ever reach EXEC, so flags update here alone.
      if (state == S_EXEC) begin
        res_q  <= alu_res;
        flag_z <= (alu_res == 8'h00);
        flag_c <= alu_c;
      end
      if ((state == S_WB) && (op_q != OP_NOP)) result_out <= res_q;
    end
  end

  // imm_q is the LDI view of the latched word; it aliases rs1/rs2 bits.
  logic unused_imm;
  assign unused_imm = ^imm_q;

endmodule
`default_nettype wire
